// File: rtl/jk_cmd_seq_if.sv
// jk_cmd_seq command port: {op, length} over a valid/ready handshake.
interface jk_cmd_seq_if #(
   parameter int CW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [CW-1:0] cmd_len;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_len,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_len,
      output cmd_ready
   );
endinterface

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: FIFO of {op,len}, plays each op for len+1 cycles.
// Define JK_CHECK_EN to build the JK flip-flop model checker on q_fb.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CW    = 4
) (
   input  logic        clk,
   input  logic        reset,
   jk_cmd_seq_if.slave cmd,
   output logic        j,
   output logic        k,
   output logic        busy,
   output logic        done,
   input  logic        q_fb,
   output logic        mismatch
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   logic [1:0]    op_mem  [DEPTH];
   logic [CW-1:0] len_mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          full, empty;
   logic          push, pop;

   state_t        state, nstate;
   logic [1:0]    op_r, nop;
   logic [CW-1:0] rem, nrem;

   assign full          = (count == (AW+1)'(DEPTH));
   assign empty         = (count == '0);
   assign cmd.cmd_ready = !full;
   assign push          = cmd.cmd_valid && !full;

   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wptr]  <= cmd.cmd_op;
         len_mem[wptr] <= cmd.cmd_len;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Pop only from registered occupancy, so a command never bypasses the FIFO.
   always_comb begin
      nstate = state;
      nop    = op_r;
      nrem   = rem;
      pop    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop    = 1'b1;
               nop    = op_mem[rptr];
               nrem   = len_mem[rptr];
               nstate = RUN;
            end
         end
         RUN: begin
            if (rem != '0) begin
               nrem = rem - CW'(1);
            end else if (!empty) begin
               pop  = 1'b1;
               nop  = op_mem[rptr];
               nrem = len_mem[rptr];
            end else begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         op_r  <= '0;
         rem   <= '0;
         j     <= 1'b0;
         k     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nstate;
         op_r  <= nop;
         rem   <= nrem;
         j     <= (nstate == RUN) && nop[1];
         k     <= (nstate == RUN) && nop[0];
         busy  <= (nstate == RUN);
         done  <= (nstate == RUN) && (nrem == '0);
      end
   end

`ifdef JK_CHECK_EN
   logic exp_q;

   // Model samples j/k at the same edge as the downstream flip-flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         unique case ({j, k})
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
         endcase
         if (q_fb != exp_q) mismatch <= 1'b1;
      end
   end
`else
   logic unused_q_fb;
   assign unused_q_fb = q_fb;
   assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq: vector table plus multi-cycle sequences.
module tb_jk_cmd_seq;
`ifdef JK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic j, k, busy, done, q_fb, mismatch;
   logic ff_q;
   logic force0 = 1'b0;

   int checks = 0;
   int failures = 0;

   jk_cmd_seq_if #(.CW(4)) cif ();

   jk_cmd_seq #(.DEPTH(4), .CW(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cif),
      .j        (j),
      .k        (k),
      .busy     (busy),
      .done     (done),
      .q_fb     (q_fb),
      .mismatch (mismatch)
   );

   always #5 clk = ~clk;

   // Reference downstream JK flip-flop
   always @(posedge clk or posedge reset) begin
      if (reset) ff_q <= 1'b0;
      else begin
         case ({j, k})
            2'b01: ff_q <= 1'b0;
            2'b10: ff_q <= 1'b1;
            2'b11: ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign q_fb = force0 ? 1'b0 : ff_q;

   logic [1:0] trace[$];
   int ndone = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) begin
      #1;
      if (mon_en && busy) trace.push_back({j, k});
      if (mon_en && done) ndone++;
   end

   typedef struct {
      logic       v;
      logic [1:0] op;
      logic [3:0] len;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {j, k, busy, done, cif.cmd_ready, mismatch};
   endfunction

   task automatic push(input logic [1:0] op, input logic [3:0] len);
      int n;
      @(negedge clk);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_len   = len;
      n = 0;
      while (!cif.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) chk("push_timeout", 1, 0);
      @(posedge clk);
      #1;
      cif.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      repeat (2) @(posedge clk);
      #1;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 200) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      logic [1:0] exp_tr[$];
      logic [1:0] bp_op  [6];
      logic [3:0] bp_len [6];
      int bad;

      tbl[0]  = '{1'b1, 2'b10, 4'd2, 6'b000010};
      tbl[1]  = '{1'b0, 2'b00, 4'd0, 6'b101010};
      tbl[2]  = '{1'b0, 2'b00, 4'd0, 6'b101010};
      tbl[3]  = '{1'b0, 2'b00, 4'd0, 6'b101110};
      tbl[4]  = '{1'b0, 2'b00, 4'd0, 6'b000010};
      tbl[5]  = '{1'b1, 2'b10, 4'd0, 6'b000010};
      tbl[6]  = '{1'b1, 2'b11, 4'd3, 6'b101110};
      tbl[7]  = '{1'b1, 2'b01, 4'd1, 6'b111010};
      tbl[8]  = '{1'b0, 2'b00, 4'd0, 6'b111010};
      tbl[9]  = '{1'b0, 2'b00, 4'd0, 6'b111010};
      tbl[10] = '{1'b0, 2'b00, 4'd0, 6'b111110};
      tbl[11] = '{1'b0, 2'b00, 4'd0, 6'b011010};
      tbl[12] = '{1'b0, 2'b00, 4'd0, 6'b011110};
      tbl[13] = '{1'b0, 2'b00, 4'd0, 6'b000010};

      cif.cmd_valid = 1'b0;
      cif.cmd_op    = 2'b00;
      cif.cmd_len   = 4'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("in_reset", {j, k, busy, done, mismatch}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("after_reset", outs(), 6'b000010);

      // Single command then back-to-back, cycle by cycle
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         cif.cmd_valid = tbl[i].v;
         cif.cmd_op    = tbl[i].op;
         cif.cmd_len   = tbl[i].len;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end
      @(negedge clk);
      cif.cmd_valid = 1'b0;

      // Backpressure: long first command, six pushes with valid held
      bp_op  = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
      bp_len = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0};
      trace.delete();
      ndone = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push(bp_op[i], bp_len[i]);
         if (i == 3) chk("ready_before_full", cif.cmd_ready, 1);
         if (i == 4) chk("ready_when_full", cif.cmd_ready, 0);
      end
      wait_idle();
      mon_en = 1'b0;
      for (int i = 0; i < 6; i++)
         for (int c = 0; c <= int'(bp_len[i]); c++)
            exp_tr.push_back({bp_op[i][1], bp_op[i][0]});
      chk("bp_trace_len", trace.size(), exp_tr.size());
      bad = 0;
      for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
         if (trace[i] != exp_tr[i]) bad++;
      chk("bp_trace_data", bad, 0);
      chk("bp_done_count", ndone, 6);
      chk("bp_idle", {j, k, busy, done, cif.cmd_ready}, 5'b00001);

      // Correct flip-flop: set, toggle x3, clear
      push(2'b10, 4'd0);
      push(2'b11, 4'd0);
      push(2'b11, 4'd0);
      push(2'b11, 4'd0);
      push(2'b01, 4'd1);
      wait_idle();
      chk("chk_clean", mismatch, 0);
      chk("ff_cleared", ff_q, 0);

      // Corrupt q_fb during a set
      push(2'b10, 4'd5);
      @(posedge clk);
      #1;
      chk("set_drive", {j, k}, 2'b10);
      @(posedge clk);
      #1;
      force0 = 1'b1;
      @(posedge clk);
      #1;
      force0 = 1'b0;
      chk("mismatch_set", mismatch, CHK);
      repeat (3) @(posedge clk);
      #1;
      chk("mismatch_sticky", mismatch, CHK);
      wait_idle();

      // Reset in the 2nd cycle of a len=7 command with two queued
      push(2'b11, 4'd7);
      push(2'b10, 4'd3);
      push(2'b01, 4'd2);
      chk("run2_drive", {j, k, busy}, 3'b111);
      #1;
      reset = 1'b1;
      #1;
      chk("reset_async", {j, k, busy, done, mismatch}, 0);
      chk("reset_ready", cif.cmd_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if ({j, k, busy, done} != 4'b0000) bad++;
      end
      chk("no_replay", bad, 0);
      chk("post_reset_ready", cif.cmd_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
